// File: rtl/lcd8080_pkg.sv
// Shared definitions for the 8080-style LCD bus target and driver.
// Command codes, controller states and small helpers.
package lcd8080_pkg;

    localparam logic [7:0] CMD_NOP     = 8'h00;
    localparam logic [7:0] CMD_SWRESET = 8'h01;
    localparam logic [7:0] CMD_RDDID   = 8'h04;
    localparam logic [7:0] CMD_CASET   = 8'h2A;
    localparam logic [7:0] CMD_PASET   = 8'h2B;
    localparam logic [7:0] CMD_RAMWR   = 8'h2C;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CASET,
        ST_PASET,
        ST_RAMWR,
        ST_RDDID
    } state_t;

    function automatic logic [15:0] clip16(
        input logic [15:0] v,
        input logic [15:0] lim
    );
        return (v > lim) ? lim : v;
    endfunction

endpackage

// File: rtl/lcd8080_sync.sv
// Two-flop synchroniser with an extra history flop for edge pulses.
// Reset loads INIT so an idle bus produces no spurious edges.
module lcd8080_sync #(
    parameter int             W    = 1,
    parameter logic [W-1:0]   INIT = '0
) (
    input  logic         clock,
    input  logic         reset,
    input  logic [W-1:0] d,
    output logic [W-1:0] q,
    output logic [W-1:0] rise,
    output logic [W-1:0] fall
);

    logic [W-1:0] s1;
    logic [W-1:0] s2;
    logic [W-1:0] s3;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            s1 <= INIT;
            s2 <= INIT;
            s3 <= INIT;
        end else begin
            s1 <= d;
            s2 <= s1;
            s3 <= s2;
        end
    end

    assign q    = s2;
    assign rise = s2 & ~s3;
    assign fall = ~s2 & s3;

endmodule

// File: rtl/lcd8080_target.sv
// Responder for the 8080 LCD bus: ILI9341 command subset, window
// decoding, framebuffer pixel writes and RDDID read-back.
module lcd8080_target
    import lcd8080_pkg::*;
#(
    parameter int         WIDTH  = 240,
    parameter int         HEIGHT = 320,
    parameter int         ADDR_W = 17,
    parameter logic [7:0] ID1    = 8'h00,
    parameter logic [7:0] ID2    = 8'h93,
    parameter logic [7:0] ID3    = 8'h41
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              csx,
    input  logic              dcx,
    input  logic              wrx,
    input  logic              rdx,
    input  logic [7:0]        data_in,
    output logic [7:0]        data_out,
    output logic              data_oe,
    output logic              pix_we,
    output logic [ADDR_W-1:0] pix_adr,
    output logic [15:0]       pix_data,
    output logic              cmd_valid,
    output logic [7:0]        cmd_code
);

    localparam logic [15:0] COL_MAX = 16'(WIDTH - 1);
    localparam logic [15:0] ROW_MAX = 16'(HEIGHT - 1);

    logic       csx_q, csx_rise, csx_fall;
    logic       dcx_q, dcx_rise, dcx_fall;
    logic       wrx_q, wrx_rise, wrx_fall;
    logic       rdx_q, rdx_rise, rdx_fall;
    logic [7:0] data_q, data_rise, data_fall;

    lcd8080_sync #(.W(1), .INIT(1'b1)) u_csx (
        .clock(clock), .reset(reset), .d(csx),
        .q(csx_q), .rise(csx_rise), .fall(csx_fall)
    );
    lcd8080_sync #(.W(1), .INIT(1'b0)) u_dcx (
        .clock(clock), .reset(reset), .d(dcx),
        .q(dcx_q), .rise(dcx_rise), .fall(dcx_fall)
    );
    lcd8080_sync #(.W(1), .INIT(1'b1)) u_wrx (
        .clock(clock), .reset(reset), .d(wrx),
        .q(wrx_q), .rise(wrx_rise), .fall(wrx_fall)
    );
    lcd8080_sync #(.W(1), .INIT(1'b1)) u_rdx (
        .clock(clock), .reset(reset), .d(rdx),
        .q(rdx_q), .rise(rdx_rise), .fall(rdx_fall)
    );
    lcd8080_sync #(.W(8), .INIT(8'h00)) u_data (
        .clock(clock), .reset(reset), .d(data_in),
        .q(data_q), .rise(data_rise), .fall(data_fall)
    );

    logic unused_edges;
    assign unused_edges = ^{csx_fall, dcx_rise, dcx_fall, wrx_fall,
                            rdx_q, data_rise, data_fall};

    logic wr_ev, cmd_ev, par_ev, rd_ev;
    assign wr_ev  = wrx_rise & ~csx_q;
    assign cmd_ev = wr_ev & ~dcx_q;
    assign par_ev = wr_ev & dcx_q;
    // A read overlapping a write strobe is a protocol error: no drive.
    assign rd_ev  = rdx_fall & ~csx_q & wrx_q;

    state_t      state, state_n;
    logic [2:0]  pcnt;
    logic [7:0]  p_hi;
    logic [15:0] sc, ec, sr, er;
    logic [15:0] col, row;
    logic [7:0]  hi;
    logic        have_hi;
    logic [2:0]  rd_idx;
    logic [7:0]  rd_byte;
    logic        win_ok;
    logic [ADDR_W-1:0] adr;

    assign win_ok = (sc <= ec) && (sr <= er);
    assign adr    = ADDR_W'(row) * ADDR_W'(WIDTH) + ADDR_W'(col);

    always_comb begin
        state_n = state;
        if (cmd_ev) begin
            unique case (1'b1)
                (data_q == CMD_CASET): state_n = ST_CASET;
                (data_q == CMD_PASET): state_n = ST_PASET;
                (data_q == CMD_RAMWR): state_n = ST_RAMWR;
                (data_q == CMD_RDDID): state_n = ST_RDDID;
                (data_q == CMD_NOP):   state_n = ST_IDLE;
                default:               state_n = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) state <= ST_IDLE;
        else        state <= state_n;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cmd_code  <= '0;
            cmd_valid <= 1'b0;
            pcnt      <= '0;
            p_hi      <= '0;
            sc        <= '0;
            ec        <= COL_MAX;
            sr        <= '0;
            er        <= ROW_MAX;
            col       <= '0;
            row       <= '0;
            hi        <= '0;
            have_hi   <= 1'b0;
            pix_we    <= 1'b0;
            pix_adr   <= '0;
            pix_data  <= '0;
        end else begin
            cmd_valid <= 1'b0;
            pix_we    <= 1'b0;
            if (cmd_ev) begin
                cmd_code  <= data_q;
                cmd_valid <= 1'b1;
                pcnt      <= '0;
                have_hi   <= 1'b0;
                if (data_q == CMD_SWRESET) begin
                    sc <= '0;
                    ec <= COL_MAX;
                    sr <= '0;
                    er <= ROW_MAX;
                end
                if (data_q == CMD_RAMWR) begin
                    col <= sc;
                    row <= sr;
                end
            end else if (par_ev) begin
                if (pcnt != 3'd4) pcnt <= pcnt + 3'd1;
                unique case (state)
                    ST_CASET, ST_PASET: begin
                        unique case (pcnt)
                            3'd0, 3'd2: p_hi <= data_q;
                            3'd1: begin
                                if (state == ST_CASET) sc <= {p_hi, data_q};
                                else                   sr <= {p_hi, data_q};
                            end
                            3'd3: begin
                                if (state == ST_CASET)
                                    ec <= clip16({p_hi, data_q}, COL_MAX);
                                else
                                    er <= clip16({p_hi, data_q}, ROW_MAX);
                            end
                            default: ;
                        endcase
                    end
                    ST_RAMWR: begin
                        if (!have_hi) begin
                            hi      <= data_q;
                            have_hi <= 1'b1;
                        end else begin
                            have_hi <= 1'b0;
                            // Inverted windows swallow pixels silently.
                            if (win_ok) begin
                                pix_we   <= 1'b1;
                                pix_data <= {hi, data_q};
                                pix_adr  <= adr;
                                if (col >= ec) begin
                                    col <= sc;
                                    row <= (row >= er) ? sr : row + 16'd1;
                                end else begin
                                    col <= col + 16'd1;
                                end
                            end
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    always_comb begin
        rd_byte = 8'h00;
        if (state == ST_RDDID) begin
            unique case (rd_idx)
                3'd1:    rd_byte = ID1;
                3'd2:    rd_byte = ID2;
                3'd3:    rd_byte = ID3;
                default: rd_byte = 8'h00;
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            data_out <= '0;
            data_oe  <= 1'b0;
            rd_idx   <= '0;
        end else begin
            if (rd_ev) begin
                data_oe  <= 1'b1;
                data_out <= rd_byte;
            end else if (rdx_rise || csx_rise) begin
                data_oe <= 1'b0;
            end
            if (cmd_ev && data_q == CMD_RDDID)
                rd_idx <= '0;
            else if (rdx_rise && !csx_q && rd_idx != 3'd4)
                rd_idx <= rd_idx + 3'd1;
        end
    end

endmodule

// File: tb/tb_lcd8080_target.sv
// Randomised bench for lcd8080_target against a behavioural panel model.
module tb_lcd8080_target;

    localparam int W = 240;
    localparam int H = 320;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        csx = 1'b1;
    logic        dcx = 1'b1;
    logic        wrx = 1'b1;
    logic        rdx = 1'b1;
    logic [7:0]  data_in = 8'h00;
    logic [7:0]  data_out;
    logic        data_oe;
    logic        pix_we;
    logic [16:0] pix_adr;
    logic [15:0] pix_data;
    logic        cmd_valid;
    logic [7:0]  cmd_code;

    lcd8080_target dut (
        .clock(clock), .reset(reset), .csx(csx), .dcx(dcx),
        .wrx(wrx), .rdx(rdx), .data_in(data_in),
        .data_out(data_out), .data_oe(data_oe),
        .pix_we(pix_we), .pix_adr(pix_adr), .pix_data(pix_data),
        .cmd_valid(cmd_valid), .cmd_code(cmd_code)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;
    int pix_cnt = 0;
    int cmd_cnt = 0;
    logic [32:0] exp_pix[$];
    logic [32:0] seen[$];
    logic [7:0]  exp_cmd[$];

    // Panel model: plain integers for the window and the write cursor.
    int         m_sc, m_ec, m_sr, m_er, m_col, m_row, m_np, m_ridx, m_phi;
    logic [7:0] m_mode;
    bit         m_hv;
    logic [7:0] m_hi;
    logic [7:0] id_tbl[5] = '{8'h00, 8'h00, 8'h93, 8'h41, 8'h00};

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    function automatic logic [32:0] seen_at(input int i);
        if (i < seen.size()) return seen[i];
        return 'x;
    endfunction

    task automatic m_reset();
        m_sc = 0; m_ec = W - 1; m_sr = 0; m_er = H - 1;
        m_col = 0; m_row = 0; m_np = 0; m_ridx = 0; m_phi = 0;
        m_mode = 8'h00; m_hv = 0; m_hi = 8'h00;
    endtask

    task automatic m_command(input logic [7:0] b);
        exp_cmd.push_back(b);
        m_np = 0;
        m_hv = 0;
        case (b)
            8'h01: begin
                m_sc = 0; m_ec = W - 1; m_sr = 0; m_er = H - 1;
                m_mode = 8'h00;
            end
            8'h04: begin m_mode = b; m_ridx = 0; end
            8'h2A, 8'h2B: m_mode = b;
            8'h2C: begin m_mode = b; m_col = m_sc; m_row = m_sr; end
            default: m_mode = 8'h00;
        endcase
    endtask

    task automatic m_param(input logic [7:0] b);
        int v;
        if ((m_mode == 8'h2A || m_mode == 8'h2B) && m_np < 4) begin
            if (m_np == 0 || m_np == 2) m_phi = b;
            v = m_phi * 256 + b;
            if (m_mode == 8'h2A) begin
                if (m_np == 1) m_sc = v;
                if (m_np == 3) m_ec = (v > W - 1) ? W - 1 : v;
            end else begin
                if (m_np == 1) m_sr = v;
                if (m_np == 3) m_er = (v > H - 1) ? H - 1 : v;
            end
        end else if (m_mode == 8'h2C) begin
            if (!m_hv) begin
                m_hi = b;
                m_hv = 1;
            end else begin
                m_hv = 0;
                if (m_sc <= m_ec && m_sr <= m_er) begin
                    exp_pix.push_back({17'(m_row * W + m_col), m_hi, b});
                    m_col++;
                    if (m_col > m_ec) begin
                        m_col = m_sc;
                        m_row++;
                        if (m_row > m_er) m_row = m_sr;
                    end
                end
            end
        end
        m_np++;
    endtask

    task automatic m_rd(output logic [7:0] e);
        e = (m_mode == 8'h04) ? id_tbl[m_ridx] : 8'h00;
        if (m_ridx < 4) m_ridx++;
    endtask

    always @(negedge clock) begin
        logic [32:0] e;
        logic [7:0]  c;
        if (reset) begin
            if (pix_we) begin
                pix_cnt++;
                seen.push_back({pix_adr, pix_data});
                checks++;
                if (exp_pix.size() == 0) begin
                    errors++;
                    $display("FAIL pix_unexpected actual=%0h required=none",
                             {pix_adr, pix_data});
                end else begin
                    e = exp_pix.pop_front();
                    if ({pix_adr, pix_data} !== e) begin
                        errors++;
                        $display("FAIL pix actual=%0h/%0h required=%0h/%0h",
                                 pix_adr, pix_data, e[32:16], e[15:0]);
                    end
                end
            end
            if (cmd_valid) begin
                cmd_cnt++;
                checks++;
                if (exp_cmd.size() == 0) begin
                    errors++;
                    $display("FAIL cmd_unexpected actual=%0h required=none",
                             cmd_code);
                end else begin
                    c = exp_cmd.pop_front();
                    if (cmd_code !== c) begin
                        errors++;
                        $display("FAIL cmd_code actual=%0h required=%0h",
                                 cmd_code, c);
                    end
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic wr_bus(input bit dc, input logic [7:0] b);
        dcx = dc;
        data_in = b;
        wrx = 1'b0;
        tick(5);
        wrx = 1'b1;
        tick(5);
    endtask

    task automatic cmd(input logic [7:0] b);
        m_command(b);
        wr_bus(1'b0, b);
    endtask

    task automatic par(input logic [7:0] b);
        m_param(b);
        wr_bus(1'b1, b);
    endtask

    task automatic rd(output logic [7:0] v);
        logic [7:0] e;
        m_rd(e);
        rdx = 1'b0;
        tick(6);
        chk("rd_oe_on", data_oe, 1);
        chk("rd_data", data_out, e);
        v = data_out;
        rdx = 1'b1;
        tick(6);
        chk("rd_oe_off", data_oe, 0);
    endtask

    task automatic chk_reset_outs(input string tag);
        chk({tag, "_data_out"}, data_out, 0);
        chk({tag, "_data_oe"}, data_oe, 0);
        chk({tag, "_pix_we"}, pix_we, 0);
        chk({tag, "_pix_adr"}, pix_adr, 0);
        chk({tag, "_pix_data"}, pix_data, 0);
        chk({tag, "_cmd_valid"}, cmd_valid, 0);
        chk({tag, "_cmd_code"}, cmd_code, 0);
    endtask

    task automatic csx_blip();
        csx = 1'b1;
        tick(6);
        csx = 1'b0;
        tick(6);
    endtask

    task automatic win_cmd(input logic [7:0] c);
        int n;
        logic [7:0] b;
        cmd(c);
        n = $urandom_range(2, 6);
        for (int i = 0; i < n; i++) begin
            if (i % 2 == 0) b = ($urandom_range(0, 7) == 0) ? 8'h01 : 8'h00;
            else            b = 8'($urandom_range(0, 40));
            par(b);
        end
    endtask

    logic [32:0] lit_pix[5] = '{
        {17'd0,   16'hF800}, {17'd1,   16'h07E0},
        {17'd240, 16'h001F}, {17'd241, 16'hFFFF},
        {17'd0,   16'hAA55}
    };
    logic [7:0] lit_rd[5] = '{8'h00, 8'h00, 8'h93, 8'h41, 8'h00};
    logic [7:0] ramwr_bytes[10] = '{8'hF8, 8'h00, 8'h07, 8'hE0, 8'h00,
                                    8'h1F, 8'hFF, 8'hFF, 8'hAA, 8'h55};

    initial begin
        int base;
        int pc;
        int cc;
        int n;
        logic [7:0]  v;
        logic [32:0] s;

        m_reset();
        tick(3);
        chk_reset_outs("rst");
        reset = 1'b1;
        tick(4);
        csx = 1'b0;
        tick(6);

        // Two-by-two window, four pixels then a wrap to the origin.
        base = seen.size();
        cmd(8'h01);
        cmd(8'h2A); par(8'h00); par(8'h00); par(8'h00); par(8'h01);
        cmd(8'h2B); par(8'h00); par(8'h00); par(8'h00); par(8'h01);
        cmd(8'h2C);
        for (int i = 0; i < 10; i++) par(ramwr_bytes[i]);
        tick(8);
        for (int i = 0; i < 5; i++) chk("lit_pix", seen_at(base + i), lit_pix[i]);

        // ID read sequence.
        cmd(8'h04);
        for (int i = 0; i < 5; i++) begin
            rd(v);
            chk("lit_rddid", v, lit_rd[i]);
        end

        // Orphan high byte is dropped by the next command.
        base = seen.size();
        cmd(8'h2C); par(8'h77);
        cmd(8'h00);
        cmd(8'h2C); par(8'h12); par(8'h34);
        tick(8);
        chk("orphan_count", seen.size(), base + 1);
        chk("orphan_pix", seen_at(base), {17'd0, 16'h1234});

        // End column beyond the panel clips to the last column.
        base = seen.size();
        cmd(8'h2A); par(8'h00); par(8'h00); par(8'h03); par(8'hE8);
        cmd(8'h2C);
        for (int i = 0; i < 241; i++) begin
            par(8'($urandom));
            par(8'($urandom));
        end
        tick(8);
        s = seen_at(base + 239);
        chk("clip_last_col", s[32:16], 239);
        s = seen_at(base + 240);
        chk("clip_wrap_row", s[32:16], 240);

        // Deselected bus traffic must be invisible.
        pc = pix_cnt;
        cc = cmd_cnt;
        csx = 1'b1;
        tick(6);
        wr_bus(1'b0, 8'h2C);
        wr_bus(1'b1, 8'h11);
        wr_bus(1'b1, 8'h22);
        wr_bus(1'b0, 8'h01);
        tick(6);
        chk("csx_hi_pix", pix_cnt, pc);
        chk("csx_hi_cmd", cmd_cnt, cc);
        csx = 1'b0;
        tick(6);

        // Reset with half a pixel pending.
        base = seen.size();
        cmd(8'h2C); par(8'h99);
        reset = 1'b0;
        #1;
        chk_reset_outs("midrst");
        m_reset();
        tick(3);
        reset = 1'b1;
        tick(4);
        cmd(8'h2C); par(8'hAB); par(8'hCD);
        tick(8);
        chk("post_reset_pix", seen_at(base), {17'd0, 16'hABCD});

        // Random command mix.
        for (int it = 0; it < 40; it++) begin
            case ($urandom_range(0, 9))
                0: win_cmd(8'h2A);
                1: win_cmd(8'h2B);
                2, 3, 4: begin
                    cmd(8'h2C);
                    n = $urandom_range(0, 24);
                    for (int i = 0; i < n; i++) begin
                        if ($urandom_range(0, 9) == 0) csx_blip();
                        par(8'($urandom));
                    end
                end
                5: begin
                    cmd(8'h04);
                    n = $urandom_range(1, 6);
                    for (int i = 0; i < n; i++) rd(v);
                end
                6: rd(v);
                7: cmd(8'h01);
                8: begin
                    cmd(8'($urandom));
                    n = $urandom_range(0, 3);
                    for (int i = 0; i < n; i++) par(8'($urandom));
                end
                default: csx_blip();
            endcase
        end

        tick(10);
        chk("pix_drain", exp_pix.size(), 0);
        chk("cmd_drain", exp_cmd.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
